icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the instruction-fetch stage and the memory controller's instruction port. It serves 32-bit instruction words to fetch with one-cycle hit latency. On a miss it requests a whole line from the memory controller (`if_en`/`if_pc`/`if_done`/`if_data`), installs it, and forwards the requested word from the returning line.

## Interface
- `LINE_BYTES`, 16: bytes per line; must equal `MEM_CTRL_IF_DATA_LEN`; power of two, ≥4.
- `LINES`, 16: number of lines; power of two.
- `clk` input 1: clock; the only clock.
- `rst` input 1: reset, asynchronous, active-high.
- `rdy` input 1: global ready; low freezes the block.
- `rollback` input 1: pipeline flush; cancels the outstanding fetch request.
- `fetch_en` input 1: fetch request valid; held with `fetch_pc` until `fetch_valid`.
- `fetch_pc` input 32: instruction address; bits [1:0] ignored.
- `fetch_valid` output 1: one-cycle pulse; `fetch_inst` is valid.
- `fetch_inst` output 32: instruction word, little-endian.
- `mem_if_en` output 1: line request to the memory controller.
- `mem_if_pc` output 32: line-aligned request address (low log2(LINE_BYTES) bits zero).
- `mem_if_done` input 1: one-cycle pulse; `mem_if_data` holds the line.
- `mem_if_data` input LINE_BYTES*8: byte i at bits [8i+7:8i] = memory[mem_if_pc+i].

## Operation
- Address split: OFF = log2(LINE_BYTES), IDX = log2(LINES). Word select = pc[OFF-1:2]. Index = pc[OFF+IDX-1:OFF]. Tag = pc[31:OFF+IDX].
- Storage: data array LINES×LINE_BYTES*8, tag array, and valid bit vector. Only the valid bits are reset. Data and tag arrays are not reset.
- States: IDLE, MISS.
- IDLE, `fetch_en`=1, no `rollback`, hit: register the selected word and pulse `fetch_valid` next cycle. Stay in IDLE.
- IDLE, `fetch_en`=1, no `rollback`, miss: set `mem_if_en`=1 and `mem_if_pc`={pc[31:OFF],0}. Latch the miss index and tag. Go to MISS.
- MISS: hold `mem_if_en` and `mem_if_pc` until `mem_if_done`. On `mem_if_done`:
  - write the line, tag, and valid=1 into the latched index;
  - drop `mem_if_en`;
  - return to IDLE.
  - Bypass: if `fetch_en`=1, `fetch_pc`[31:OFF] equals the latched line address, no cancel is pending, and `rollback`=0, register the word from `mem_if_data` and pulse `fetch_valid` next cycle.
- Rollback:
  - In IDLE: no request or lookup that cycle, and no `fetch_valid` in the following cycle.
  - In MISS: set a cancel flag. The fill still completes and the line is still installed, because the memory controller cannot abort. The bypass is suppressed, and the flag clears on `mem_if_done`.
- Conflicting miss: the new line overwrites the old index unconditionally. There is no write-back.
- `mem_if_data` is sampled only in the `mem_if_done` cycle.

## Timing
- Reset values: `fetch_valid`=0, `fetch_inst`=0, `mem_if_en`=0, `mem_if_pc`=0, state=IDLE, all valid bits 0, cancel flag 0.
- Hit: `fetch_en` sampled at edge t → `fetch_valid`=1 during cycle t+1.
- Miss:
  - `fetch_en` at edge t → `mem_if_en`=1 from t+1.
  - `mem_if_done` at edge d → `fetch_valid`=1 and `mem_if_en`=0 during cycle d+1.
- `mem_if_en` deasserts in the cycle after `mem_if_done`, which the memory controller spends idling, so no duplicate request is issued.
- Back-to-back hits: one instruction per cycle while `fetch_en` stays high. Fetch drops or changes `fetch_pc` in the `fetch_valid` cycle; a still-asserted request in that cycle is a new request.
- `rdy`=0: all registers hold, except `fetch_valid`, which is forced to 0. `mem_if_done` cannot arrive while `rdy`=0, because the memory controller is also stalled.
- `rst` mid-MISS: the state returns to IDLE immediately and the valid bits are cleared. The memory controller is reset by the same `rst`.

## Structure
- `cons.v` gets `ICACHE_LINES`, `ICACHE_LINE_BYTES`, and derived `ICACHE_OFF_WID`/`ICACHE_IDX_WID`/`ICACHE_TAG_WID`. `ICACHE_LINE_BYTES` is defined as `MEM_CTRL_IF_DATA_LEN`.
- Single module `icache`, no sub-module. The arrays are `reg` arrays inside it.

## Test plan
- Cold miss: reset, then `fetch_en`, pc=0x0000_0004. Expect `mem_if_pc`=0x0, and the word at bytes 4..7 of the returned line (e.g. 0x00100093) on `fetch_valid` in the cycle after `mem_if_done`.
- Hit: pc=0x0000_0008 after the previous scenario. Expect `fetch_valid` one cycle later, with no `mem_if_en`.
- Conflict: fetch 0x0000_0000, then 0x0000_0100 (same index with 16×16 B), then 0x0000_0000. Expect three memory requests, each with correct data.
- Rollback mid-MISS at pc=0x40:
  - the fill completes and no `fetch_valid` is produced;
  - a re-fetch of 0x44 then hits in one cycle.
- `rdy` low for 3 cycles during a hit: `fetch_valid` is delayed by exactly 3 cycles and the data is unchanged.
- Async `rst` pulse between edges while in MISS: all outputs go to 0 immediately, and the next fetch of the previously cached line misses.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - icache geometry constants and controller state encoding
package icache_pkg;

  localparam int MEM_CTRL_IF_DATA_LEN = 16;

  localparam int ICACHE_LINES      = 16;
  localparam int ICACHE_LINE_BYTES = MEM_CTRL_IF_DATA_LEN;
  localparam int ICACHE_OFF_WID    = $clog2(ICACHE_LINE_BYTES);
  localparam int ICACHE_IDX_WID    = $clog2(ICACHE_LINES);
  localparam int ICACHE_TAG_WID    = 32 - ICACHE_OFF_WID - ICACHE_IDX_WID;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with one-cycle hits and fill bypass
module icache
  import icache_pkg::*;
#(
  parameter int LINE_BYTES = ICACHE_LINE_BYTES,
  parameter int LINES      = ICACHE_LINES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    fetch_en,
  input  logic [31:0]             fetch_pc,
  output logic                    fetch_valid,
  output logic [31:0]             fetch_inst,
  output logic                    mem_if_en,
  output logic [31:0]             mem_if_pc,
  input  logic                    mem_if_done,
  input  logic [LINE_BYTES*8-1:0] mem_if_data
);

  localparam int OFF = $clog2(LINE_BYTES);
  localparam int IDX = $clog2(LINES);
  localparam int TAG = 32 - OFF - IDX;
  localparam int LW  = LINE_BYTES * 8;

  logic [LW-1:0]    data_mem [LINES];
  logic [TAG-1:0]   tag_mem  [LINES];
  logic [LINES-1:0] valid;

  icache_state_t state;
  logic          cancel;

  logic [IDX-1:0]    pc_idx;
  logic [TAG-1:0]    pc_tag;
  logic [31-OFF:0]   pc_line;
  logic [IDX-1:0]    miss_idx;
  logic [TAG-1:0]    miss_tag;
  logic              hit;
  logic              fill;
  logic              bypass;
  logic [31:0]       hit_word;
  logic [31:0]       fill_word;

  // Word lane inside a line; works down to 4-byte lines where there is no word select.
  function automatic logic [31:0] pick_word(input logic [LW-1:0] line, input logic [31:0] pc);
    logic [OFF+2:0] bit_off;
    bit_off      = {pc[OFF-1:0], 3'b000};
    bit_off[4:0] = '0;
    return line[bit_off +: 32];
  endfunction

  // The latched request address doubles as the miss index/tag latch.
  assign miss_idx = mem_if_pc[OFF+IDX-1:OFF];
  assign miss_tag = mem_if_pc[31:OFF+IDX];

  always_comb begin
    pc_idx    = fetch_pc[OFF+IDX-1:OFF];
    pc_tag    = fetch_pc[31:OFF+IDX];
    pc_line   = fetch_pc[31:OFF];
    hit       = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    hit_word  = pick_word(data_mem[pc_idx], fetch_pc);
    fill_word = pick_word(mem_if_data, fetch_pc);
    fill      = rdy && (state == ST_MISS) && mem_if_done;
    bypass    = fetch_en && !rollback && !cancel && (pc_line == mem_if_pc[31:OFF]);
  end

  // Data and tag storage carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[miss_idx] <= mem_if_data;
      tag_mem[miss_idx]  <= miss_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      valid       <= '0;
      cancel      <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_inst  <= '0;
      mem_if_en   <= 1'b0;
      mem_if_pc   <= '0;
    end else if (!rdy) begin
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fetch_en && !rollback) begin
            if (hit) begin
              fetch_inst  <= hit_word;
              fetch_valid <= 1'b1;
            end else begin
              mem_if_en <= 1'b1;
              mem_if_pc <= {pc_line, {OFF{1'b0}}};
              state     <= ST_MISS;
            end
          end
        end
        ST_MISS: begin
          if (mem_if_done) begin
            valid[miss_idx] <= 1'b1;
            mem_if_en       <= 1'b0;
            cancel          <= 1'b0;
            state           <= ST_IDLE;
            if (bypass) begin
              fetch_inst  <= fill_word;
              fetch_valid <= 1'b1;
            end
          end else if (rollback) begin
            // The controller cannot abort a fill, so only the forwarded word is dropped.
            cancel <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;

  logic         clk;
  logic         rst;
  logic         rdy;
  logic         rollback;
  logic         fetch_en;
  logic [31:0]  fetch_pc;
  logic         fetch_valid;
  logic [31:0]  fetch_inst;
  logic         mem_if_en;
  logic [31:0]  mem_if_pc;
  logic         mem_if_done;
  logic [127:0] mem_if_data;

  int tests_run;
  int tests_failed;

  icache dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .rollback    (rollback),
    .fetch_en    (fetch_en),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .mem_if_en   (mem_if_en),
    .mem_if_pc   (mem_if_pc),
    .mem_if_done (mem_if_done),
    .mem_if_data (mem_if_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word at address a is 0x1000_0000 + a, except address 4 holds addi x1,x0,1.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0010_0093;
    return 32'h1000_0000 + a;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = mem_word(base + 32'(4*i));
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic hit_fetch(input logic [31:0] pc, input logic [31:0] exp, input string tag);
    fetch_en = 1'b1;
    fetch_pc = pc;
    step();
    check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    check({tag, "_inst"}, fetch_inst, exp);
    check({tag, "_no_req"}, 32'(mem_if_en), 32'd0);
    fetch_en = 1'b0;
  endtask

  task automatic miss_fetch(input logic [31:0] pc, input logic [31:0] exp, input string tag);
    fetch_en = 1'b1;
    fetch_pc = pc;
    step();
    check({tag, "_req"}, 32'(mem_if_en), 32'd1);
    check({tag, "_req_pc"}, mem_if_pc, pc & 32'hFFFF_FFF0);
    check({tag, "_no_valid"}, 32'(fetch_valid), 32'd0);
    step();
    check({tag, "_req_held"}, 32'(mem_if_en), 32'd1);
    mem_if_done = 1'b1;
    mem_if_data = line_of(pc & 32'hFFFF_FFF0);
    step();
    mem_if_done = 1'b0;
    mem_if_data = '0;
    check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    check({tag, "_inst"}, fetch_inst, exp);
    check({tag, "_req_drop"}, 32'(mem_if_en), 32'd0);
    fetch_en = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    rdy          = 1'b1;
    rollback     = 1'b0;
    fetch_en     = 1'b0;
    fetch_pc     = '0;
    mem_if_done  = 1'b0;
    mem_if_data  = '0;
    step();
    step();
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_inst", fetch_inst, 32'd0);
    check("rst_mem_if_en", 32'(mem_if_en), 32'd0);
    check("rst_mem_if_pc", mem_if_pc, 32'd0);
    rst = 1'b0;
    step();

    miss_fetch(32'h0000_0004, 32'h0010_0093, "cold");
    step();
    hit_fetch(32'h0000_0008, 32'h1000_0008, "hit8");
    step();

    // Back-to-back hits: a new pc presented in the valid cycle is a new request.
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_000C;
    step();
    check("b2b_first", fetch_inst, 32'h1000_000C);
    fetch_pc = 32'h0000_0000;
    step();
    check("b2b_second_valid", 32'(fetch_valid), 32'd1);
    check("b2b_second", fetch_inst, 32'h1000_0000);
    fetch_en = 1'b0;
    step();

    // Rollback in IDLE suppresses the lookup.
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_0008;
    rollback = 1'b1;
    step();
    check("rb_idle_valid", 32'(fetch_valid), 32'd0);
    check("rb_idle_req", 32'(mem_if_en), 32'd0);
    rollback = 1'b0;
    fetch_en = 1'b0;
    step();

    miss_fetch(32'h0000_0100, 32'h1000_0100, "conf1");
    step();
    miss_fetch(32'h0000_0000, 32'h1000_0000, "conf2");
    step();
    miss_fetch(32'h0000_0104, 32'h1000_0104, "conf3");
    step();

    // Rollback mid-miss: fill installs, bypass suppressed.
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_0040;
    step();
    check("rb_miss_req", 32'(mem_if_en), 32'd1);
    check("rb_miss_req_pc", mem_if_pc, 32'h0000_0040);
    rollback = 1'b1;
    step();
    rollback    = 1'b0;
    step();
    mem_if_done = 1'b1;
    mem_if_data = line_of(32'h0000_0040);
    step();
    mem_if_done = 1'b0;
    mem_if_data = '0;
    fetch_en    = 1'b0;
    check("rb_miss_no_valid", 32'(fetch_valid), 32'd0);
    check("rb_miss_req_drop", 32'(mem_if_en), 32'd0);
    step();
    check("rb_miss_no_late_valid", 32'(fetch_valid), 32'd0);
    hit_fetch(32'h0000_0044, 32'h1000_0044, "rb_refetch");
    step();

    // rdy low for three edges delays the hit by exactly three cycles.
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_0048;
    rdy      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rdy_stall_valid", 32'(fetch_valid), 32'd0);
    end
    rdy = 1'b1;
    step();
    check("rdy_valid", 32'(fetch_valid), 32'd1);
    check("rdy_inst", fetch_inst, 32'h1000_0048);
    fetch_en = 1'b0;
    step();

    // Asynchronous reset between edges while a miss is outstanding.
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_0050;
    step();
    check("arst_pre_req", 32'(mem_if_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_if_en", 32'(mem_if_en), 32'd0);
    check("arst_mem_if_pc", mem_if_pc, 32'd0);
    check("arst_fetch_inst", fetch_inst, 32'd0);
    check("arst_fetch_valid", 32'(fetch_valid), 32'd0);
    rst      = 1'b0;
    fetch_en = 1'b0;
    step();
    miss_fetch(32'h0000_0044, 32'h1000_0044, "arst_refetch");
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
